sdp_ram_pipe: RTL and testbench
===============================

SDP_RAM_PIPE -- requirements
Module: sdp_ram_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits (multiple of 8 when BYTE_WRITE=1).
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, meaning number of words (any value >= 2).
REQ-003 SHALL have parameter BYTE_WRITE, default 0, meaning per-byte write strobes when 1, single word strobe when 0.
REQ-004 SHALL have parameter READ_LATENCY, default 1, meaning cycles from read accept to dvalb (legal 1..3).
REQ-005 SHALL have parameter WRITE_FIRST, default 1, meaning same-address collision returns new data when 1, old data when 0.
REQ-006 SHALL have parameter INIT_ON_RESET, default 1, meaning zero-fill the memory after reset when 1.
REQ-007 SHALL derive ADDR_WIDTH = $clog2(MEM_DEPTH) and STRB_WIDTH = BYTE_WRITE ? DATA_WIDTH/8 : 1.
REQ-008 clk  input  1  the single clock; all logic on rising edge.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 addra  input  ADDR_WIDTH  write address.
REQ-011 wena  input  STRB_WIDTH  write strobes, bit i enables byte lane i (or the whole word when STRB_WIDTH=1).
REQ-012 dina  input  DATA_WIDTH  write data.
REQ-013 addrb  input  ADDR_WIDTH  read address.
REQ-014 renb  input  1  read request.
REQ-015 doutb  output  DATA_WIDTH  read data.
REQ-016 dvalb  output  1  read data valid, one-cycle pulse per accepted read.
REQ-017 init_busy  output  1  high while the zero-fill sequencer runs; port inputs ignored.

Function
REQ-018 FSM states SHALL be ST_INIT and ST_READY; reset exit goes to ST_INIT if INIT_ON_RESET=1, else ST_READY.
REQ-019 In ST_INIT an address counter SHALL write zero to address 0..MEM_DEPTH-1, one per cycle, then enter ST_READY; init_busy = (state==ST_INIT).
REQ-020 In ST_INIT wena and renb SHALL be ignored: no memory update, no dvalb.
REQ-021 In ST_READY, on a rising edge, every lane with wena bit set SHALL be written from dina to addra; other lanes unchanged.
REQ-022 A read with renb=1 at edge N SHALL produce doutb and dvalb=1 at edge N+READ_LATENCY; back-to-back reads every cycle SHALL be supported with no bubbles.
REQ-023 doutb SHALL hold its last value while dvalb=0.
REQ-024 Same-cycle write and read to the same address with WRITE_FIRST=1 SHALL return, per lane, new data for strobed lanes and old data for the rest; with WRITE_FIRST=0 SHALL return old data.
REQ-025 Addresses >= MEM_DEPTH (non-power-of-two depth) SHALL ignore writes; reads SHALL return 0 with dvalb=1.

Reset
REQ-026 While rst_n=0: doutb=0, dvalb=0, read pipeline cleared, init counter=0, init_busy=INIT_ON_RESET.
REQ-027 Reset asserted mid-operation SHALL discard in-flight reads (no dvalb after release for them); memory contents are undefined unless re-zeroed by INIT_ON_RESET.
REQ-028 Memory array itself SHALL have no reset (inferable as block RAM).

Structure
REQ-029 Package sdp_ram_pkg SHALL hold the state enum (ST_INIT, ST_READY) and the strobe-width helper function.
REQ-030 Read latency stages beyond the array read SHALL live in sub-module ram_rd_pipe (data + valid delay line, parameter STAGES, async active-low reset).

Verification
REQ-031 MEM_DEPTH=16, INIT_ON_RESET=1: release rst_n -> init_busy high exactly 16 cycles, then read of addr 9 returns 0x00000000.
REQ-032 Write 350 to addr 5, 670 to addr 7; renb addr 5 then addr 7 on consecutive cycles, READ_LATENCY=2 -> dvalb on two consecutive cycles, doutb 350 then 670, 2 cycles after each request.
REQ-033 BYTE_WRITE=1, addr 3 holds 0x11223344; write 0xAABBCCDD with wena=4'b0101 -> read returns 0x11BB33DD.
REQ-034 Collision addr 5 old 350, write 961 + read same cycle: WRITE_FIRST=1 -> 961; WRITE_FIRST=0 -> 350.
REQ-035 Reset pulsed one cycle after renb with READ_LATENCY=3 -> no dvalb after release, doutb=0, init re-runs.
REQ-036 renb=1 and wena=1 during init_busy -> no dvalb, post-init read of that address returns 0.

Source files
------------

// File: rtl/sdp_ram_pipe_pkg.sv
// Shared types and helpers for the simple dual-port RAM with pipelined read.
package sdp_ram_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } ram_state_e;

   // Word-wide strobe when byte writes are off, one strobe per byte otherwise.
   function automatic int strb_width(input int data_width, input int byte_write);
      return (byte_write != 0) ? data_width / 8 : 1;
   endfunction

endpackage

// File: rtl/sdp_ram_pipe_if.sv
// Write/read port bundle for sdp_ram_pipe; master drives requests, slave is the RAM.
interface sdp_ram_pipe_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = 1
);
   logic [ADDR_WIDTH-1:0] addra;
   logic [STRB_WIDTH-1:0] wena;
   logic [DATA_WIDTH-1:0] dina;
   logic [ADDR_WIDTH-1:0] addrb;
   logic                  renb;
   logic [DATA_WIDTH-1:0] doutb;
   logic                  dvalb;
   logic                  init_busy;

   modport master (
      output addra, wena, dina, addrb, renb,
      input  doutb, dvalb, init_busy
   );

   modport slave (
      input  addra, wena, dina, addrb, renb,
      output doutb, dvalb, init_busy
   );
endinterface

// File: rtl/sdp_ram_pipe_rd_pipe.sv
// Extra read-latency stages: delays data and valid together; data only moves with valid,
// so the last stage holds the most recent read result between pulses.
module ram_rd_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int STAGES     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vld_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  vld_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   if (STAGES == 0) begin : g_bypass
      assign vld_o  = vld_i;
      assign data_o = data_i;
   end else begin : g_stages
      logic [STAGES-1:0]                 vld_q;
      logic [STAGES-1:0][DATA_WIDTH-1:0] data_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
         end else begin
            vld_q[0] <= vld_i;
            if (vld_i) data_q[0] <= data_i;
            for (int i = 1; i < STAGES; i++) begin
               vld_q[i] <= vld_q[i-1];
               if (vld_q[i-1]) data_q[i] <= data_q[i-1];
            end
         end
      end

      assign vld_o  = vld_q[STAGES-1];
      assign data_o = data_q[STAGES-1];
   end

endmodule

// File: rtl/sdp_ram_pipe.sv
// Simple dual-port RAM (one write, one read port) with optional byte strobes,
// configurable read latency and a zero-fill sequencer after reset.
//
//   state    | meaning
//   ST_INIT  | zero-filling one word per cycle, port requests ignored
//   ST_READY | normal write/read operation
module sdp_ram_pipe
   import sdp_ram_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int MEM_DEPTH     = 1024,
   parameter int BYTE_WRITE    = 0,
   parameter int READ_LATENCY  = 1,
   parameter int WRITE_FIRST   = 1,
   parameter int INIT_ON_RESET = 1
) (
   input logic           clk,
   input logic           rst_n,
   sdp_ram_pipe_if.slave bus
);

   localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
   localparam int STRB_WIDTH = strb_width(DATA_WIDTH, BYTE_WRITE);
   localparam int LANE_W     = DATA_WIDTH / STRB_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH+1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   ram_state_e            state_q;
   logic [ADDR_WIDTH-1:0] init_cnt_q;
   logic                  init_busy_q;

   logic [STRB_WIDTH-1:0] wr_lane;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wa_ok;
   logic                  rd_ok;
   logic                  rd_fire;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  rd_vld_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [DATA_WIDTH-1:0] rd_data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
         init_cnt_q  <= '0;
         init_busy_q <= (INIT_ON_RESET != 0);
      end else begin
         case (state_q)
            ST_INIT: begin
               if (init_cnt_q == LAST_ADDR) begin
                  state_q     <= ST_READY;
                  init_busy_q <= 1'b0;
                  init_cnt_q  <= '0;
               end else begin
                  init_cnt_q  <= init_cnt_q + ADDR_WIDTH'(1);
               end
            end
            default: begin
               state_q     <= ST_READY;
               init_busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Out-of-range addresses only exist for non-power-of-two depths.
   assign wa_ok   = ({1'b0, bus.addra} < DEPTH_X);
   assign rd_ok   = ({1'b0, bus.addrb} < DEPTH_X);
   assign rd_fire = (state_q == ST_READY) && bus.renb;

   always_comb begin
      wr_lane = '0;
      wr_addr = bus.addra;
      wr_data = bus.dina;
      if (state_q == ST_INIT) begin
         wr_lane = '1;
         wr_addr = init_cnt_q;
         wr_data = '0;
      end else if (wa_ok) begin
         wr_lane = bus.wena;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (wr_lane[i]) mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
      end
   end

   // Same-address write forwarding is per lane so unstrobed lanes still show the stored bytes.
   always_comb begin
      rd_word = '0;
      if (rd_ok) begin
         rd_word = mem[bus.addrb];
         if ((WRITE_FIRST != 0) && (state_q == ST_READY) && (bus.addra == bus.addrb)) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
               if (bus.wena[i]) rd_word[i*LANE_W +: LANE_W] = bus.dina[i*LANE_W +: LANE_W];
            end
         end
      end
   end

   assign rd_data_d = rd_fire ? rd_word : rd_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_vld_q  <= rd_fire;
         rd_data_q <= rd_data_d;
      end
   end

   ram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (READ_LATENCY - 1)
   ) u_rd_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (rd_vld_q),
      .data_i (rd_data_q),
      .vld_o  (bus.dvalb),
      .data_o (bus.doutb)
   );

   assign bus.init_busy = init_busy_q;

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// Directed bench for sdp_ram_pipe: A = 16 words, byte strobes, latency 2, write-first;
// B = 12 words, word strobe, latency 3, read-first.
module tb_sdp_ram_pipe;

   logic clk;
   logic rst_n;
   int   vec_cnt;
   int   err_cnt;

   sdp_ram_pipe_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .STRB_WIDTH(4)) ifa ();
   sdp_ram_pipe_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .STRB_WIDTH(1)) ifb ();

   sdp_ram_pipe #(
      .DATA_WIDTH(32), .MEM_DEPTH(16), .BYTE_WRITE(1),
      .READ_LATENCY(2), .WRITE_FIRST(1), .INIT_ON_RESET(1)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa)
   );

   sdp_ram_pipe #(
      .DATA_WIDTH(32), .MEM_DEPTH(12), .BYTE_WRITE(0),
      .READ_LATENCY(3), .WRITE_FIRST(0), .INIT_ON_RESET(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ifa.addra = '0; ifa.wena = '0; ifa.dina = '0; ifa.addrb = '0; ifa.renb = 1'b0;
      ifb.addra = '0; ifb.wena = '0; ifb.dina = '0; ifb.addrb = '0; ifb.renb = 1'b0;
   endtask

   task automatic write_a(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      ifa.addra = addr; ifa.dina = data; ifa.wena = strb;
      step();
      ifa.wena = '0;
   endtask

   task automatic write_b(input logic [3:0] addr, input logic [31:0] data);
      ifb.addra = addr; ifb.dina = data; ifb.wena = 1'b1;
      step();
      ifb.wena = '0;
   endtask

   // Any write set up by the caller shares the request cycle (collision cases).
   task automatic read_a(input logic [3:0] addr, input logic [31:0] exp, input string name);
      ifa.addrb = addr; ifa.renb = 1'b1;
      step();
      ifa.renb = 1'b0; ifa.wena = '0;
      vec_cnt++;
      if (ifa.dvalb !== 1'b0) begin
         err_cnt++; $display("FAIL %s early_dvalb got=%b want=0", name, ifa.dvalb);
      end
      step();
      vec_cnt++;
      if (ifa.dvalb !== 1'b1 || ifa.doutb !== exp) begin
         err_cnt++;
         $display("FAIL %s data got dvalb=%b doutb=%h want dvalb=1 doutb=%h", name, ifa.dvalb, ifa.doutb, exp);
      end
      step();
      vec_cnt++;
      if (ifa.dvalb !== 1'b0) begin
         err_cnt++; $display("FAIL %s pulse_len got dvalb=%b want=0", name, ifa.dvalb);
      end
   endtask

   task automatic read_b(input logic [3:0] addr, input logic [31:0] exp, input string name);
      ifb.addrb = addr; ifb.renb = 1'b1;
      step();
      ifb.renb = 1'b0; ifb.wena = '0;
      for (int k = 0; k < 2; k++) begin
         vec_cnt++;
         if (ifb.dvalb !== 1'b0) begin
            err_cnt++; $display("FAIL %s early_dvalb[%0d] got=%b want=0", name, k, ifb.dvalb);
         end
         step();
      end
      vec_cnt++;
      if (ifb.dvalb !== 1'b1 || ifb.doutb !== exp) begin
         err_cnt++;
         $display("FAIL %s data got dvalb=%b doutb=%h want dvalb=1 doutb=%h", name, ifb.dvalb, ifb.doutb, exp);
      end
      step();
      vec_cnt++;
      if (ifb.dvalb !== 1'b0) begin
         err_cnt++; $display("FAIL %s pulse_len got dvalb=%b want=0", name, ifb.dvalb);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) step();
      vec_cnt++;
      if (ifa.doutb !== 32'h0 || ifa.dvalb !== 1'b0 || ifa.init_busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL rst_a got doutb=%h dvalb=%b busy=%b want 0/0/1", ifa.doutb, ifa.dvalb, ifa.init_busy);
      end
      vec_cnt++;
      if (ifb.doutb !== 32'h0 || ifb.dvalb !== 1'b0 || ifb.init_busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL rst_b got doutb=%h dvalb=%b busy=%b want 0/0/1", ifb.doutb, ifb.dvalb, ifb.init_busy);
      end
   endtask

   // Release reset with write and read requests to addr 9 held during zero-fill.
   task automatic test_init();
      int  busy_a;
      int  busy_b;
      bit  dv_seen;
      busy_a = 0; busy_b = 0; dv_seen = 1'b0;
      ifa.addra = 4'd9; ifa.dina = 32'hFFFF_FFFF; ifa.wena = 4'hF; ifa.addrb = 4'd9; ifa.renb = 1'b1;
      ifb.addra = 4'd9; ifb.dina = 32'hFFFF_FFFF; ifb.wena = 1'b1; ifb.addrb = 4'd9; ifb.renb = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (ifa.init_busy === 1'b1) busy_a++;
         else begin ifa.renb = 1'b0; ifa.wena = '0; end
         if (ifb.init_busy === 1'b1) busy_b++;
         else begin ifb.renb = 1'b0; ifb.wena = '0; end
         if (ifa.dvalb !== 1'b0 || ifb.dvalb !== 1'b0) dv_seen = 1'b1;
         step();
      end
      vec_cnt++;
      if (busy_a != 16) begin err_cnt++; $display("FAIL init_len_a got=%0d want=16", busy_a); end
      vec_cnt++;
      if (busy_b != 12) begin err_cnt++; $display("FAIL init_len_b got=%0d want=12", busy_b); end
      vec_cnt++;
      if (dv_seen) begin err_cnt++; $display("FAIL init_dvalb got=1 want=0"); end
      read_a(4'd9, 32'h0, "init_zero_a9");
      read_b(4'd9, 32'h0, "init_zero_b9");
   endtask

   task automatic test_back_to_back();
      write_a(4'd5, 32'd350, 4'hF);
      write_a(4'd7, 32'd670, 4'hF);
      ifa.addrb = 4'd5; ifa.renb = 1'b1;
      step();
      ifa.addrb = 4'd7;
      vec_cnt++;
      if (ifa.dvalb !== 1'b0) begin err_cnt++; $display("FAIL b2b_early got dvalb=%b want=0", ifa.dvalb); end
      step();
      ifa.renb = 1'b0;
      vec_cnt++;
      if (ifa.dvalb !== 1'b1 || ifa.doutb !== 32'd350) begin
         err_cnt++; $display("FAIL b2b_first got dvalb=%b doutb=%0d want 1/350", ifa.dvalb, ifa.doutb);
      end
      step();
      vec_cnt++;
      if (ifa.dvalb !== 1'b1 || ifa.doutb !== 32'd670) begin
         err_cnt++; $display("FAIL b2b_second got dvalb=%b doutb=%0d want 1/670", ifa.dvalb, ifa.doutb);
      end
      step();
      vec_cnt++;
      if (ifa.dvalb !== 1'b0 || ifa.doutb !== 32'd670) begin
         err_cnt++; $display("FAIL b2b_hold got dvalb=%b doutb=%0d want 0/670", ifa.dvalb, ifa.doutb);
      end
   endtask

   task automatic test_byte_write();
      write_a(4'd3, 32'h1122_3344, 4'hF);
      write_a(4'd3, 32'hAABB_CCDD, 4'b0101);
      read_a(4'd3, 32'h11BB_33DD, "byte_strobe");
   endtask

   task automatic test_collision();
      ifa.addra = 4'd5; ifa.dina = 32'd961; ifa.wena = 4'hF;
      read_a(4'd5, 32'd961, "coll_wf1");
      ifa.addra = 4'd3; ifa.dina = 32'h0000_0000; ifa.wena = 4'b0010;
      read_a(4'd3, 32'h11BB_00DD, "coll_wf1_lane");
      write_b(4'd5, 32'd350);
      ifb.addra = 4'd5; ifb.dina = 32'd961; ifb.wena = 1'b1;
      read_b(4'd5, 32'd350, "coll_wf0");
      read_b(4'd5, 32'd961, "coll_wf0_after");
   endtask

   task automatic test_out_of_range();
      write_b(4'd11, 32'h0000_0077);
      write_b(4'd13, 32'h0000_0055);
      read_b(4'd13, 32'h0, "oor_read");
      read_b(4'd11, 32'h0000_0077, "last_addr");
   endtask

   task automatic test_reset_inflight();
      bit dv_seen;
      int n;
      dv_seen = 1'b0;
      read_b(4'd5, 32'd961, "pre_rst_read");
      ifb.addrb = 4'd5; ifb.renb = 1'b1;
      step();
      ifb.renb = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (ifb.dvalb !== 1'b0 || ifb.doutb !== 32'h0 || ifb.init_busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL rst_mid got dvalb=%b doutb=%h busy=%b want 0/0/1", ifb.dvalb, ifb.doutb, ifb.init_busy);
      end
      step();
      rst_n = 1'b1;
      n = 0;
      while ((ifa.init_busy === 1'b1 || ifb.init_busy === 1'b1) && n < 40) begin
         if (ifb.dvalb !== 1'b0) dv_seen = 1'b1;
         step();
         n++;
      end
      vec_cnt++;
      if (n >= 40) begin err_cnt++; $display("FAIL reinit_timeout got busy after %0d cycles want idle", n); end
      vec_cnt++;
      if (dv_seen || ifb.dvalb !== 1'b0) begin err_cnt++; $display("FAIL stale_dvalb got=1 want=0"); end
      vec_cnt++;
      if (ifb.doutb !== 32'h0) begin err_cnt++; $display("FAIL post_rst_dout got=%h want=0", ifb.doutb); end
      read_b(4'd5, 32'h0, "rezero_b5");
      read_a(4'd7, 32'h0, "rezero_a7");
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      test_reset();
      test_init();
      test_back_to_back();
      test_byte_write();
      test_collision();
      test_out_of_range();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
